// File: rtl/subtracter_n_if.sv
// Operand/result bundle for subtracter_n: operands under in_valid, registered
// difference and status flags under out_valid.
interface subtracter_n_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] y;
  logic             borrow;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b,
    input  out_valid, y, borrow, overflow, zero
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, y, borrow, overflow, zero
  );
endinterface

// File: rtl/subtracter_n.sv
// Registered WIDTH-bit subtractor y = a - b built from a ripple-borrow chain of
// full-subtractor cells, with borrow, signed-overflow and zero flags.
module subtracter_n #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  subtracter_n_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   bchain;
  logic [WIDTH-1:0] d;
  logic             core_borrow;
  logic             core_overflow;
  logic             core_zero;

  assign bchain[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign d[i]          = bus.a[i] ^ bus.b[i] ^ bchain[i];
    assign bchain[i + 1] = (~bus.a[i] & bus.b[i]) | (~(bus.a[i] ^ bus.b[i]) & bchain[i]);
  end

  assign core_borrow   = bchain[WIDTH];
  // Operands of differing sign whose result sign departs from the minuend's.
  assign core_overflow = (bus.a[MSB] != bus.b[MSB]) && (d[MSB] != bus.a[MSB]);
  assign core_zero     = ~|d;

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.y         <= '0;
      bus.borrow    <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.zero      <= 1'b1;
    end else begin
      bus.out_valid <= bus.in_valid;
      // Load only on valid so idle (possibly X) operands never reach the outputs.
      if (bus.in_valid) begin
        bus.y        <= d;
        bus.borrow   <= core_borrow;
        bus.overflow <= core_overflow;
        bus.zero     <= core_zero;
      end
    end
  end

endmodule

// File: tb/tb_subtracter_n.sv
// Self-checking bench for subtracter_n: directed cases plus randomized traffic
// against an arithmetic reference model, on WIDTH = 8 and WIDTH = 16 instances.
module tb_subtracter_n;

  logic clk;
  logic rst_n;

  subtracter_n_if #(.WIDTH(8))  bus8  ();
  subtracter_n_if #(.WIDTH(16)) bus16 ();

  subtracter_n #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  subtracter_n #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  typedef struct {
    logic [15:0] y;
    logic        borrow;
    logic        overflow;
    logic        zero;
  } res_t;

  // Expected state of the 8-bit instance's outputs.
  logic       m_valid;
  logic [7:0] m_y;
  logic       m_borrow;
  logic       m_overflow;
  logic       m_zero;

  function automatic res_t ref_sub(input int w, input longint a, input longint b);
    res_t   r;
    longint diff;
    longint sa;
    longint sb;
    longint sdiff;
    longint modulus;
    modulus    = longint'(1) << w;
    diff       = a - b;
    r.y        = 16'((diff + modulus) % modulus);
    r.borrow   = (a < b);
    sa         = (a >= modulus / 2) ? a - modulus : a;
    sb         = (b >= modulus / 2) ? b - modulus : b;
    sdiff      = sa - sb;
    r.overflow = (sdiff > modulus / 2 - 1) || (sdiff < -(modulus / 2));
    r.zero     = (r.y == 16'd0);
    return r;
  endfunction

  function automatic void model_step8(input logic v, input logic [7:0] a, input logic [7:0] b);
    res_t r;
    m_valid = v;
    if (v) begin
      r          = ref_sub(8, longint'(a), longint'(b));
      m_y        = r.y[7:0];
      m_borrow   = r.borrow;
      m_overflow = r.overflow;
      m_zero     = r.zero;
    end
  endfunction

  function automatic void model_reset8();
    m_valid    = 1'b0;
    m_y        = 8'd0;
    m_borrow   = 1'b0;
    m_overflow = 1'b0;
    m_zero     = 1'b1;
  endfunction

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b);
    bus8.in_valid = v;
    bus8.a        = a;
    bus8.b        = b;
    model_step8(v, a, b);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] got8;
    logic [19:0] got16;
    rst_n          = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus16.in_valid = 1'b0;
    bus16.a        = '0;
    bus16.b        = '0;
    model_reset8();
    repeat (3) @(posedge clk);
    #1;
    got8 = {bus8.out_valid, bus8.y, bus8.borrow, bus8.overflow, bus8.zero};
    checks++;
    if (got8 !== {1'b0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset8 got=%h expected=%h", got8, {1'b0, 8'd0, 1'b0, 1'b0, 1'b1});
    end
    got16 = {bus16.out_valid, bus16.y, bus16.borrow, bus16.overflow, bus16.zero};
    checks++;
    if (got16 !== {1'b0, 16'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset16 got=%h expected=%h", got16, {1'b0, 16'd0, 1'b0, 1'b0, 1'b1});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [11:0] got;
    for (int i = 0; i < 100; i++) begin
      drive8(1'b1, 8'(i + 2), 8'(i));
      got = {bus8.out_valid, bus8.y, bus8.borrow, bus8.overflow, bus8.zero};
      checks++;
      if (got !== {1'b1, 8'd2, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL sweep i=%0d got=%h expected=%h", i, got, {1'b1, 8'd2, 1'b0, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_underflow();
    logic [11:0] got;
    drive8(1'b1, 8'd0, 8'd1);
    got = {bus8.out_valid, bus8.y, bus8.borrow, bus8.overflow, bus8.zero};
    checks++;
    if (got !== {1'b1, 8'd255, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL underflow_0m1 got=%h expected=%h", got, {1'b1, 8'd255, 1'b1, 1'b0, 1'b0});
    end
    drive8(1'b1, 8'd3, 8'd200);
    got = {bus8.out_valid, bus8.y, bus8.borrow, bus8.overflow, bus8.zero};
    checks++;
    if (got !== {1'b1, 8'd59, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL underflow_3m200 got=%h expected=%h", got, {1'b1, 8'd59, 1'b1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_overflow();
    logic [11:0] got;
    drive8(1'b1, 8'd128, 8'd1);
    got = {bus8.out_valid, bus8.y, bus8.borrow, bus8.overflow, bus8.zero};
    checks++;
    if (got !== {1'b1, 8'd127, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL overflow_128m1 got=%h expected=%h", got, {1'b1, 8'd127, 1'b0, 1'b1, 1'b0});
    end
    drive8(1'b1, 8'd127, 8'd255);
    got = {bus8.out_valid, bus8.y, bus8.borrow, bus8.overflow, bus8.zero};
    checks++;
    if (got !== {1'b1, 8'd128, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL overflow_127m255 got=%h expected=%h", got, {1'b1, 8'd128, 1'b1, 1'b1, 1'b0});
    end
  endtask

  task automatic test_zero_hold();
    logic [11:0] got;
    drive8(1'b1, 8'd5, 8'd5);
    got = {bus8.out_valid, bus8.y, bus8.borrow, bus8.overflow, bus8.zero};
    checks++;
    if (got !== {1'b1, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL zero_5m5 got=%h expected=%h", got, {1'b1, 8'd0, 1'b0, 1'b0, 1'b1});
    end
    // Idle cycles with unknown operands: result must hold and stay clean.
    for (int k = 0; k < 2; k++) begin
      bus8.in_valid = 1'b0;
      bus8.a        = 'x;
      bus8.b        = 'x;
      m_valid       = 1'b0;
      @(posedge clk);
      #1;
      got = {bus8.out_valid, bus8.y, bus8.borrow, bus8.overflow, bus8.zero};
      checks++;
      if (got !== {1'b0, 8'd0, 1'b0, 1'b0, 1'b1} || $isunknown(got)) begin
        failures++;
        $display("FAIL hold_x k=%0d got=%h expected=%h", k, got, {1'b0, 8'd0, 1'b0, 1'b0, 1'b1});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] got;
    drive8(1'b1, 8'd50, 8'd20);
    bus8.a = 8'd90;
    bus8.b = 8'd7;
    #3;
    rst_n = 1'b0;
    model_reset8();
    #1;
    got = {bus8.out_valid, bus8.y, bus8.borrow, bus8.overflow, bus8.zero};
    checks++;
    if (got !== {1'b0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid_async got=%h expected=%h", got, {1'b0, 8'd0, 1'b0, 1'b0, 1'b1});
    end
    @(posedge clk);
    #1;
    got = {bus8.out_valid, bus8.y, bus8.borrow, bus8.overflow, bus8.zero};
    checks++;
    if (got !== {1'b0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid_held got=%h expected=%h", got, {1'b0, 8'd0, 1'b0, 1'b0, 1'b1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive8(1'b1, 8'd10, 8'd4);
    got = {bus8.out_valid, bus8.y, bus8.borrow, bus8.overflow, bus8.zero};
    checks++;
    if (got !== {1'b1, 8'd6, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_after got=%h expected=%h", got, {1'b1, 8'd6, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_back_to_back_random();
    logic [11:0] got;
    logic [11:0] exp;
    logic        v;
    logic [7:0]  a;
    logic [7:0]  b;
    for (int n = 0; n < 300; n++) begin
      v = ($urandom_range(0, 3) != 0);
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      drive8(v, a, b);
      got = {bus8.out_valid, bus8.y, bus8.borrow, bus8.overflow, bus8.zero};
      exp = {m_valid, m_y, m_borrow, m_overflow, m_zero};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random n=%0d a=%0d b=%0d v=%0b got=%h expected=%h", n, a, b, v, got, exp);
      end
    end
  endtask

  task automatic test_width16();
    logic [19:0] got;
    logic [19:0] exp;
    res_t        r;
    bus16.in_valid = 1'b1;
    bus16.a        = 16'h0000;
    bus16.b        = 16'h0001;
    @(posedge clk);
    #1;
    got = {bus16.out_valid, bus16.y, bus16.borrow, bus16.overflow, bus16.zero};
    checks++;
    if (got !== {1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL width16_0m1 got=%h expected=%h", got, {1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0});
    end
    for (int n = 0; n < 40; n++) begin
      bus16.a = 16'($urandom);
      bus16.b = (n == 0) ? 16'h0001 : 16'($urandom);
      if (n == 0) bus16.a = 16'h8000;
      r   = ref_sub(16, longint'(bus16.a), longint'(bus16.b));
      exp = {1'b1, r.y, r.borrow, r.overflow, r.zero};
      @(posedge clk);
      #1;
      got = {bus16.out_valid, bus16.y, bus16.borrow, bus16.overflow, bus16.zero};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL width16_random n=%0d got=%h expected=%h", n, got, exp);
      end
    end
    bus16.in_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_sweep();
    test_underflow();
    test_overflow();
    test_zero_hold();
    test_reset_mid();
    test_back_to_back_random();
    test_width16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
